// File: rtl/snn_pkg.sv
// Shared widths, saturation and bus-slicing helpers for the LIF spiking layer.
package snn_pkg;

    localparam int FACTOR_W = 4;

    function automatic int syn_width(input int in_num_pow2);
        return in_num_pow2 + 2;
    endfunction

    function automatic int mem_width(input int in_num_pow2);
        return in_num_pow2 + 4;
    endfunction

    // Clamp a wide signed value into the signed range of an m-bit word
    function automatic logic signed [31:0] sat_m(input logic signed [31:0] val, input int m);
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (m - 1)) - 32'sd1;
        min_v = -(32'sd1 <<< (m - 1));
        if (val > max_v) begin
            sat_m = max_v;
        end else if (val < min_v) begin
            sat_m = min_v;
        end else begin
            sat_m = val;
        end
    endfunction

    function automatic int weight_idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

    function automatic int factor_lo(input int j);
        return FACTOR_W * j;
    endfunction

    function automatic int addend_lo(input int j, input int w);
        return w * j;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: binary-weight synaptic sum, batch norm,
// leaky saturating membrane and soft-reset spike output.
module lif_neuron
    import snn_pkg::*;
#(
    parameter  int in_num_pow2 = 8,
    localparam int K = 32'd1 << in_num_pow2,
    localparam int W = syn_width(in_num_pow2),
    localparam int M = mem_width(in_num_pow2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [K-1:0]          x,
    input  logic [K-1:0]          w_col,
    input  logic [K-1:0]          en_col,
    input  logic [2:0]            beta_shift,
    input  logic signed [W-1:0]   minus_teta,
    input  logic [FACTOR_W-1:0]   bn_factor,
    input  logic signed [W-1:0]   bn_addend,
    output logic                  spike
);

    localparam logic signed [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    logic signed [W-1:0]  acc_s;
    logic signed [31:0]   bn_s;
    logic signed [31:0]   u_ext_s;
    logic signed [31:0]   dec_s;
    logic signed [31:0]   v_s;
    logic signed [31:0]   sum_s;
    logic                 fire_s;
    logic signed [M-1:0]  u_next_s;
    logic signed [M-1:0]  u_r;
    logic                 spike_r;

    // Synaptic sum: enabled active inputs add +1 or -1; range is +/-K so W bits suffice
    always_comb begin
        acc_s = '0;
        for (int i = 0; i < K; i++) begin
            if (x[i] && en_col[i]) begin
                if (w_col[i]) begin
                    acc_s = acc_s + ONE_W;
                end else begin
                    acc_s = acc_s - ONE_W;
                end
            end else begin
                acc_s = acc_s;
            end
        end
    end

    // Batch norm, leak, integrate and fire, all at 32-bit width before clamping to M bits
    always_comb begin
        bn_s    = sat_m(32'(acc_s) * $signed({28'd0, bn_factor}) + 32'(bn_addend), M);
        u_ext_s = 32'(u_r);
        if (beta_shift == 3'd0) begin
            dec_s = u_ext_s;
        end else begin
            dec_s = u_ext_s - (u_ext_s >>> beta_shift);
        end
        v_s    = sat_m(dec_s + bn_s, M);
        sum_s  = v_s + 32'(minus_teta);
        fire_s = (sum_s >= 32'sd0);
        if (fire_s) begin
            u_next_s = M'(sat_m(sum_s, M));
        end else begin
            u_next_s = M'(v_s);
        end
    end

    // Membrane and spike registers advance only on enabled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_r     <= '0;
            spike_r <= 1'b0;
        end else if (ce) begin
            u_r     <= u_next_s;
            spike_r <= fire_s;
        end else begin
            u_r     <= u_r;
            spike_r <= spike_r;
        end
    end

    assign spike = spike_r;

endmodule

// File: rtl/layer.sv
// Fully-connected layer of LIF neurons; slices the flat weight, enable and
// batch-norm buses into one lif_neuron per output spike.
module layer
    import snn_pkg::*;
#(
    parameter  int in_num_pow2 = 8,
    parameter  int neurons     = 64,
    localparam int K = 32'd1 << in_num_pow2,
    localparam int W = syn_width(in_num_pow2)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ce,
    input  logic [K-1:0]                   x,
    input  logic [K*neurons-1:0]           w,
    input  logic [K*neurons-1:0]           connection_enabled,
    input  logic [2:0]                     beta_shift,
    input  logic [W-1:0]                   minus_teta,
    input  logic [FACTOR_W*neurons-1:0]    BN_factor,
    input  logic [W*neurons-1:0]           BN_addend,
    output logic [neurons-1:0]             spike_out
);

    for (genvar j = 0; j < neurons; j++) begin : g_neuron
        logic [K-1:0] w_col_s;
        logic [K-1:0] en_col_s;

        // Bit i*N+j of the flat buses feeds input i of neuron j
        for (genvar i = 0; i < K; i++) begin : g_tap
            assign w_col_s[i]  = w[weight_idx(i, j, neurons)];
            assign en_col_s[i] = connection_enabled[weight_idx(i, j, neurons)];
        end

        lif_neuron #(
            .in_num_pow2 (in_num_pow2)
        ) u_neuron (
            .clk        (clk),
            .rst_n      (rst_n),
            .ce         (ce),
            .x          (x),
            .w_col      (w_col_s),
            .en_col     (en_col_s),
            .beta_shift (beta_shift),
            .minus_teta (minus_teta),
            .bn_factor  (BN_factor[factor_lo(j) +: FACTOR_W]),
            .bn_addend  (BN_addend[addend_lo(j, W) +: W]),
            .spike      (spike_out[j])
        );
    end

endmodule

// File: tb/tb_layer.sv
// Self-checking bench for layer (K=4, N=2) using a behavioural neuron model
// feeding an expected-spike queue.
module tb_layer;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [3:0] x;
    logic [7:0] w;
    logic [7:0] connection_enabled;
    logic [2:0] beta_shift;
    logic [3:0] minus_teta;
    logic [7:0] BN_factor;
    logic [7:0] BN_addend;
    logic [1:0] spike_out;

    int errors = 0;
    int checks = 0;

    int         u_m [2];
    logic [1:0] spk_m;
    logic [1:0] exp_q [$];

    layer #(.in_num_pow2(2), .neurons(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ce                 (ce),
        .x                  (x),
        .w                  (w),
        .connection_enabled (connection_enabled),
        .beta_shift         (beta_shift),
        .minus_teta         (minus_teta),
        .BN_factor          (BN_factor),
        .BN_addend          (BN_addend),
        .spike_out          (spike_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp6(input int v);
        if (v > 31) return 31;
        if (v < -32) return -32;
        return v;
    endfunction

    // Reference neuron update from the current inputs; queues the expected spike vector
    task automatic model_push();
        int acc, bn, dec, v, mt, f, a;
        logic fire;
        logic [1:0] nxt;
        nxt = spk_m;
        for (int j = 0; j < 2; j++) begin
            acc = 0;
            for (int i = 0; i < 4; i++)
                if (x[i] && connection_enabled[i*2+j]) acc += w[i*2+j] ? 1 : -1;
            f  = int'(BN_factor[4*j +: 4]);
            a  = int'($signed(BN_addend[4*j +: 4]));
            mt = int'($signed(minus_teta));
            bn = clamp6(acc * f + a);
            dec = (beta_shift == 3'd0) ? u_m[j] : u_m[j] - (u_m[j] >>> beta_shift);
            v = clamp6(dec + bn);
            fire = ((v + mt) >= 0);
            if (ce) begin
                u_m[j] = fire ? clamp6(v + mt) : v;
                nxt[j] = fire;
            end
        end
        spk_m = nxt;
        exp_q.push_back(spk_m);
    endtask

    task automatic step(input string name);
        logic [1:0] e;
        model_push();
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, spike_out);
        end else begin
            e = exp_q.pop_front();
            if (spike_out !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", name, spike_out, e);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        u_m[0] = 0;
        u_m[1] = 0;
        spk_m = 2'b00;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_common();
        ce = 1'b1;
        BN_factor = 8'h11;
        BN_addend = 8'h00;
        beta_shift = 3'd0;
        connection_enabled = 8'hFF;
        w = 8'hFF;
        x = 4'b1111;
        minus_teta = 4'hA;   // -6
    endtask

    task automatic test_reset();
        set_common();
        rst_n = 1'b0;
        u_m[0] = 0; u_m[1] = 0; spk_m = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (spike_out !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold: got %b expected 00", spike_out);
            end
        end
        rst_n = 1'b1;
        step("reset_run0");
        step("reset_run1");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (spike_out !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: got %b expected 00", spike_out);
        end
        u_m[0] = 0; u_m[1] = 0; spk_m = 2'b00;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("reset_restart");
    endtask

    task automatic test_threshold();
        logic [1:0] pat [6];
        pat = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11};
        set_common();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step("threshold_sb");
            checks++;
            if (spike_out !== pat[k]) begin
                errors++;
                $display("FAIL threshold_seq[%0d]: got %b expected %b", k, spike_out, pat[k]);
            end
        end
    endtask

    task automatic test_saturation();
        set_common();
        w = 8'h00;
        apply_reset();
        for (int k = 0; k < 12; k++) step("saturation_low");
        w = 8'hFF;
        for (int k = 0; k < 12; k++) step("saturation_recover");
    endtask

    task automatic test_pruning();
        set_common();
        connection_enabled = 8'b0000_0010;
        x = 4'b0001;
        minus_teta = 4'hF;   // -1
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            step("prune_sb");
            checks++;
            if (spike_out !== 2'b10) begin
                errors++;
                $display("FAIL prune_n1: got %b expected 10", spike_out);
            end
        end
        connection_enabled = 8'b0000_0100;
        x = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step("prune_swap_sb");
            checks++;
            if (spike_out !== 2'b01) begin
                errors++;
                $display("FAIL prune_n0: got %b expected 01", spike_out);
            end
        end
    endtask

    task automatic test_bn_leak();
        logic [1:0] pat [6];
        set_common();
        x = 4'b0011;
        BN_factor = 8'h33;
        BN_addend = 8'hEE;   // -2 per neuron
        minus_teta = 4'hC;   // -4: bn=4 fires on the first edge
        apply_reset();
        step("bn_sb");
        checks++;
        if (spike_out !== 2'b11) begin
            errors++;
            $display("FAIL bn_fire: got %b expected 11", spike_out);
        end
        pat = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
        minus_teta = 4'h9;   // -7
        beta_shift = 3'd1;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step("leak_sb");
            checks++;
            if (spike_out !== pat[k]) begin
                errors++;
                $display("FAIL leak_seq[%0d]: got %b expected %b", k, spike_out, pat[k]);
            end
        end
    endtask

    task automatic test_ce_hold();
        set_common();
        apply_reset();
        step("ce_pre0");
        step("ce_pre1");
        ce = 1'b0;
        x = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step("ce_hold_sb");
            checks++;
            if (spike_out !== 2'b11) begin
                errors++;
                $display("FAIL ce_hold: got %b expected 11", spike_out);
            end
        end
        ce = 1'b1;
        x = 4'b1111;
        for (int k = 0; k < 4; k++) step("ce_resume");
    endtask

    task automatic test_back_to_back();
        set_common();
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            ce                 = ($urandom_range(0, 3) != 0);
            x                  = 4'($urandom);
            w                  = 8'($urandom);
            connection_enabled = 8'($urandom);
            beta_shift         = 3'($urandom_range(0, 4));
            minus_teta         = 4'($urandom);
            BN_factor          = 8'($urandom);
            BN_addend          = 8'($urandom);
            step("random_sb");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_common();
        test_reset();
        test_threshold();
        test_saturation();
        test_pruning();
        test_bn_leak();
        test_ce_hold();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer.md
Name: layer

Overview:
- One fully-connected layer of leaky integrate-and-fire (LIF) spiking neurons with 1-bit binary weights and per-neuron batch-norm scale and offset.
- Takes a spike vector from the previous layer (or the network input) and produces one registered spike vector per clock-enabled cycle.
- Instantiated once per layer and cascaded: one layer's spike_out drives the next layer's x.

Parameters:
- in_num_pow2, default 8: log2 of the input count; K = 2**in_num_pow2 inputs.
- neurons, default 64: number of neurons N.
- Derived constant W = in_num_pow2+2: signed synaptic-sum width.
- Derived constant M = in_num_pow2+4: signed membrane width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  active-low reset; one clock, reset asynchronous and active-low.
- ce  in  1  clock enable; state advances only when 1.
- x  in  K  input spikes.
- w  in  K*N  weight bits; bit i*N+j is input i → neuron j; 1 = +1, 0 = -1.
- connection_enabled  in  K*N  same indexing; 0 = synapse pruned (contributes 0).
- beta_shift  in  3  leak shift, shared by the layer.
- minus_teta  in  W  signed negated firing threshold, shared.
- BN_factor  in  4*N  unsigned 4-bit scale; neuron j at bits [4j+3:4j].
- BN_addend  in  W*N  signed offset; neuron j at bits [W*j+W-1:W*j].
- spike_out  out  N  registered spikes, bit j = neuron j.

Behaviour:
- Synaptic sum, combinational, W-bit signed: acc_j = Σ_i (x[i] & en[i*N+j]) ? (w[i*N+j] ? +1 : -1) : 0. Range ±K, never overflows.
- Batch norm: bn_j = sat_M(acc_j * BN_factor_j + sext(BN_addend_j)). Factor is unsigned 0..15. Compute at full width, then saturate to M bits.
- Leak: dec_j = u_j - (u_j >>> beta_shift) when beta_shift≠0; dec_j = u_j when beta_shift=0. Shift is arithmetic.
- Integrate: v_j = sat_M(dec_j + bn_j).
- Fire: spike_j = (v_j + sext(minus_teta)) >= 0. Compute in M+1 bits, i.e. fire when v_j ≥ teta.
- Soft reset on fire: u_j_next = spike_j ? sat_M(v_j + minus_teta) : v_j.
- Saturation: sat_M clamps to [-2^(M-1), 2^(M-1)-1]. No wrap-around anywhere.
- On a rising clk edge with ce=1: u_j ← u_j_next and spike_out[j] ← spike_j.
- With ce=0: u and spike_out hold.
- Latency: x/parameters to spike_out is 1 clk edge with ce=1. No handshake.
- Reset: rst_n=0 asynchronously clears all u_j to 0 and spike_out to 0, mid-operation included. The first enabled edge after release integrates from u=0.
- All neurons update in parallel and independently.
- Positive minus_teta (negative threshold) is legal: the neuron fires whenever v ≥ teta.

Decomposition:
- Package snn_pkg holds:
  - width functions for W and M from in_num_pow2;
  - sat_M saturation function;
  - bit-index helpers for the weight, factor and addend slices.
- One sub-module, lif_neuron: one synaptic sum, BN, membrane and spike per neuron.
- layer is a generate loop of N lif_neuron instances that slices w, connection_enabled, BN_factor and BN_addend.

Test Plan:
Common setup unless stated: in_num_pow2=2 (K=4), neurons=2, W=4, M=6, BN_factor=1, BN_addend=0, beta_shift=0.
- Reset: hold rst_n=0 with x=4'b1111 and ce=1 → spike_out=2'b00. Assert rst_n asynchronously between edges → outputs clear immediately.
- Threshold: all enabled, w all 1, x=4'b1111, minus_teta=-6 → acc=4 each cycle. u goes 4 → (v=8, spike, u=2) → (v=6, spike, u=0) → 4. spike_out sequence per neuron is 0, 1, 1, 0, 1, 1, …
- Saturation: w all 0, x=4'b1111, minus_teta=-6 → u goes -4, -8, …, -32 and stays at -32. spike_out stays 0.
- Pruning and weight indexing: connection_enabled enables only bit 0*N+1 (input 0 → neuron 1) with w=1, x=4'b0001, minus_teta=-1 → neuron 1 spikes every cycle, neuron 0 stays 0.
- BN and leak:
  - BN_factor=3, BN_addend=-2 with acc=2 → bn=4.
  - beta_shift=1 from u=8 → dec=4.
  - ce=0 for 3 cycles → u and spike_out unchanged.
